// File: rtl/minisys_md_pkg.sv
// minisys_md_pkg: shared definitions for the Minisys multiply/divide path.
// Used by the multiply/divide unit, the decoder and the hazard unit.
//   - op encodings carried on mdopE
//   - state encoding of the iterative unit
//   - iteration count and start-to-strobe latency
package minisys_md_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam int MD_ITER    = 32;
  localparam int MD_LATENCY = 34;

  // Counter value at which the last CALC iteration runs (counter then wraps to 0).
  localparam logic [4:0] MD_CNT_LAST = 5'(MD_ITER - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } md_state_e;

  // Divide ops have bit 1 set.
  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  // Signed variants (mult, div) have bit 0 clear.
  function automatic logic md_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/minisys_muldiv.sv
// minisys_muldiv: iterative multiply/divide unit of the Minisys EX stage.
// Executes mult/multu (radix-2 shift-add) and div/divu (restoring) on operand
// magnitudes over 32 cycles, applies the sign correction in one FIX cycle and
// presents HI/LO with a one-cycle write strobe. Fixed 34-cycle latency.
// Ports:
//   clock, resetn      rising-edge clock, async active-low reset
//   mdstartE, mdopE    start request (IDLE only) and op code
//   srcaE, srcbE       rs (multiplicand/dividend), rt (multiplier/divisor)
//   mdflushE           synchronous cancel
//   busy               unit occupied (registered)
//   mdcsE              HI/LO write strobe (registered)
//   mdhidataE          HI: product[63:32] or remainder
//   mdlodataE          LO: product[31:0] or quotient
module minisys_muldiv
  import minisys_md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            mdstartE,
  input  logic [1:0]      mdopE,
  input  logic [XLEN-1:0] srcaE,
  input  logic [XLEN-1:0] srcbE,
  input  logic            mdflushE,
  output logic            busy,
  output logic            mdcsE,
  output logic [XLEN-1:0] mdhidataE,
  output logic [XLEN-1:0] mdlodataE
);

  md_state_e         state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;
  logic              dz_q, dz_d;
  logic [XLEN-1:0]   raw_a_q, raw_a_d;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [XLEN-1:0]   opd_q, opd_d;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, remaining dividend bits / quotient bits}.
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              busy_q, busy_d;
  logic              mdcs_q, mdcs_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;

  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] prod_neg;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  assign a_mag = (md_is_signed(mdopE) && srcaE[XLEN-1]) ? -srcaE : srcaE;
  assign b_mag = (md_is_signed(mdopE) && srcbE[XLEN-1]) ? -srcbE : srcbE;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opd_q};
  // 33-bit trial {remainder, next dividend bit} against the divisor. The
  // difference is below the divisor when it succeeds, so 32 bits hold it.
  assign div_ge   = acc_q[2*XLEN-1:XLEN-1] >= {1'b0, opd_q};
  assign div_rem  = acc_q[2*XLEN-2:XLEN-1] - opd_q;
  assign prod_neg = -acc_q;
  assign quo_fix  = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  // Remainder follows the dividend's sign.
  assign rem_fix  = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  // Next-state, datapath iteration and result loading.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    dz_d    = dz_q;
    raw_a_d = raw_a_q;
    opd_d   = opd_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (mdstartE && !mdflushE) begin
          state_d = ST_CALC;
          cnt_d   = 5'd0;
          op_d    = mdopE;
          neg_a_d = md_is_signed(mdopE) & srcaE[XLEN-1];
          neg_b_d = md_is_signed(mdopE) & srcbE[XLEN-1];
          dz_d    = md_is_div(mdopE) && (srcbE == {XLEN{1'b0}});
          raw_a_d = srcaE;
          if (md_is_div(mdopE)) begin
            opd_d = b_mag;
            acc_d = {{XLEN{1'b0}}, a_mag};
          end else begin
            opd_d = a_mag;
            acc_d = {{XLEN{1'b0}}, b_mag};
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (mdflushE) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
          if (md_is_div(op_q)) begin
            if (div_ge) begin
              acc_d = {div_rem, acc_q[XLEN-2:0], 1'b1};
            end else begin
              acc_d = {acc_q[2*XLEN-2:0], 1'b0};
            end
          end else begin
            if (acc_q[0]) begin
              acc_d = {mul_sum, acc_q[XLEN-1:1]};
            end else begin
              acc_d = {1'b0, acc_q[2*XLEN-1:1]};
            end
          end
          if (cnt_q == MD_CNT_LAST) begin
            state_d = ST_FIX;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_FIX: begin
        if (mdflushE) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
          if (dz_q) begin
            hi_d = raw_a_q;
            lo_d = {XLEN{1'b1}};
          end else if (md_is_div(op_q)) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else if (neg_a_q ^ neg_b_q) begin
            hi_d = prod_neg[2*XLEN-1:XLEN];
            lo_d = prod_neg[XLEN-1:0];
          end else begin
            hi_d = acc_q[2*XLEN-1:XLEN];
            lo_d = acc_q[XLEN-1:0];
          end
        end
      end
      ST_DONE: begin
        // The strobe of this cycle already counts; flush or not, go idle.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    mdcs_d = (state_d == ST_DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 2'b00;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      dz_q    <= 1'b0;
      raw_a_q <= {XLEN{1'b0}};
      opd_q   <= {XLEN{1'b0}};
      acc_q   <= {(2*XLEN){1'b0}};
      busy_q  <= 1'b0;
      mdcs_q  <= 1'b0;
      hi_q    <= {XLEN{1'b0}};
      lo_q    <= {XLEN{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      dz_q    <= dz_d;
      raw_a_q <= raw_a_d;
      opd_q   <= opd_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      mdcs_q  <= mdcs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy      = busy_q;
  assign mdcsE     = mdcs_q;
  assign mdhidataE = hi_q;
  assign mdlodataE = lo_q;

endmodule

// File: doc/minisys_muldiv.md
# minisys_muldiv

Iterative multiply/divide unit for the Minisys EX stage, executing mult, multu, div and divu. It produces the HI/LO result pair plus the one-cycle write strobe that travels down the pipeline as the mdcs/mdhidata/mdlodata bundle to the write-back stage. While an operation runs, the hazard unit uses `busy` to stall dependent mfhi/mflo and any new mult/div.

## Interface
Parameters:
- `XLEN`, 32: operand width. Only 32 is supported.

Ports:
- `clock`, in, 1: single clock. Everything is rising-edge.
- `resetn`, in, 1: asynchronous, active-low reset.
- `mdstartE`, in, 1: start request. Sampled only in IDLE.
- `mdopE`, in, 2: operation code. 00 mult, 01 multu, 10 div, 11 divu.
- `srcaE`, in, 32: rs operand. Multiplicand or dividend.
- `srcbE`, in, 32: rt operand. Multiplier or divisor.
- `mdflushE`, in, 1: synchronous cancel from exception or branch flush.
- `busy`, out, 1: unit is occupied.
- `mdcsE`, out, 1: one-cycle HI/LO write strobe.
- `mdhidataE`, out, 32: HI result. For multiply this is product[63:32]; for divide it is the remainder.
- `mdlodataE`, out, 32: LO result. For multiply this is product[31:0]; for divide it is the quotient.

## Operation
- States:
  - IDLE: wait for start.
  - CALC: 32 iterations.
  - FIX: sign correction.
  - DONE: strobe cycle.
- Reset values: state IDLE, `busy`=0, `mdcsE`=0, `mdhidataE`=0, `mdlodataE`=0, all internal counters and registers 0.
- Acceptance:
  - In IDLE, `mdstartE`=1 and `mdflushE`=0 at an edge latches op, operands and the sign flags, and moves to CALC.
  - For signed ops, operands are converted to magnitudes at latch time.
- CALC, multiply: radix-2 shift-add on a 64-bit accumulator, one multiplier bit per cycle.
- CALC, divide: restoring divide, one quotient bit per cycle. Uses a 33-bit trial subtract on {remainder, dividend MSB}.
- CALC uses a 5-bit iteration counter. It exits to FIX after the 32nd iteration (counter wraps 31→0).
- FIX, signed multiply: negate the 64-bit product if the operand signs differ.
- FIX, signed divide:
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend is negative. The remainder takes the dividend's sign.
- FIX then loads the result registers and moves to DONE.
- DONE: `mdcsE`=1 for exactly this cycle, then IDLE.
- `mdhidataE`/`mdlodataE` hold their last value until the next DONE.
- Divide by zero (srcbE=0, div or divu):
  - Result is HI = srcaE (raw, unconverted) and LO = 32'hFFFF_FFFF.
  - Sign fix is skipped.
  - Latency is unchanged.
- Signed overflow: 0x8000_0000 / 0xFFFF_FFFF gives LO=0x8000_0000, HI=0. This falls out of the magnitude path and needs no special case.
- Flush:
  - `mdflushE`=1 in CALC, FIX or DONE returns to IDLE at that edge.
  - If flush lands in DONE, the strobe already visible in that cycle still counts. The flush only prevents further activity.
  - A flush in CALC or FIX produces no strobe and leaves the result registers untouched.
  - Flush and start together in IDLE: flush wins and the start is not accepted.
- `mdstartE` outside IDLE is ignored. Queueing the request is the stall logic's job.
- `resetn` deasserted (pulled low) mid-operation: immediate return to the reset values. No strobe is produced.

## Timing
- Start sampled at edge 0 (cycle 0 has `mdstartE`=1).
- `busy`=1 in cycles 1–34.
- CALC occupies cycles 1–32.
- FIX occupies cycle 33.
- DONE occupies cycle 34: `mdcsE`=1, with valid `mdhidataE`/`mdlodataE`.
- Cycle 35: `busy`=0 and state IDLE. A start in cycle 35 is accepted.
- Fixed latency: 34 cycles from start to strobe for every op, operand value and divide-by-zero case.
- `busy` and `mdcsE` are registered outputs with no combinational path from inputs.

## Structure
- Shared package `minisys_md_pkg`, holding:
  - Op encodings `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`.
  - The state enum.
  - `MD_ITER`=32 and `MD_LATENCY`=34.
- The decoder and hazard unit import the same package.
- Single module. No sub-module is warranted. The shared 64-bit shift register and adder/subtractor live inline.

## Test plan
- **Signed multiply:** mult 0x0000_0007 × 0xFFFF_FFFD → HI=0xFFFF_FFFF, LO=0xFFFF_FFEB, `mdcsE` high only in cycle 34.
- **Unsigned multiply extreme:** multu 0xFFFF_FFFF × 0xFFFF_FFFF → HI=0xFFFF_FFFE, LO=0x0000_0001.
- **Signed divide:**
  - div 0xFFFF_FFF9 (−7) / 2 → LO=0xFFFF_FFFD, HI=0xFFFF_FFFF.
  - div 0x8000_0000 / 0xFFFF_FFFF → LO=0x8000_0000, HI=0.
- **Divide by zero:** divu 0x0000_1234 / 0 → HI=0x0000_1234, LO=0xFFFF_FFFF at cycle 34; div −5 / 0 → HI=0xFFFF_FFFB, LO=0xFFFF_FFFF.
- **Flush:** flush in cycle 10 → no strobe, `busy`=0 from cycle 11, previous HI/LO unchanged; a start in cycle 11 completes correctly at cycle 45.
- **Reset and ignored start:**
  - `resetn` pulled low in cycle 20 of an op → all outputs 0 immediately, no strobe after release.
  - A start during `busy` is ignored, so only one strobe appears.
